dp_ram_sync_init: RTL and testbench
===================================

// Module: dp_ram_sync_init
// PURPOSE
//  Single-clock, true dual-port RAM; next generation of the team's dual-port memory.
//  Adds parametrised width/depth, selectable read latency, collision detection, read-valid strobes
//  and a post-reset hardware clear of the array.
//  Sits behind two independent requesters (port A, port B), e.g. a producer/consumer buffer.
// PARAMETERS
//  DATA_W    8  data word width in bits
//  ADDR_W    4  address width; DEPTH = 2**ADDR_W words
//  READ_LAT  1  read latency in cycles, legal values 1 or 2 (anything else: $error at elaboration)
// PORTS
//  clk         in   1         single clock, all logic on posedge
//  rst         in   1         synchronous reset, active-high
//  a_en        in   1         port A request valid
//  a_wr        in   1         port A 1=write, 0=read (qualified by a_en)
//  a_addr      in   ADDR_W    port A address
//  a_din       in   DATA_W    port A write data
//  a_dout      out  DATA_W    port A read data
//  a_rvalid    out  1         port A read data valid, 1-cycle pulse per read
//  b_*         --   --        identical set for port B (b_en,b_wr,b_addr,b_din,b_dout,b_rvalid)
//  init_done   out  1         1 = clear finished, ports accepted
//  collision   out  1         1-cycle pulse: same-address conflict detected
// BEHAVIOUR
//  Reset: rst sampled high at posedge -> a_dout=b_dout=0, a_rvalid=b_rvalid=0, collision=0, init_done=0.
//   Also read pipeline flushed, FSM=CLEAR, clr_ptr=0. Held while rst=1.
//  FSM CLEAR: each cycle with rst=0 writes 0 to mem[clr_ptr], clr_ptr++.
//   After writing DEPTH-1 -> READY; init_done=1 from the cycle after the last clear write.
//   Clear takes exactly DEPTH cycles.
//  In CLEAR all port requests ignored: no write, no rvalid, no collision.
//  FSM READY: en&wr -> mem[addr]<=din at posedge.
//   en&!wr -> dout=mem[addr], rvalid=1 exactly READ_LAT cycles after the request edge.
//  Back-to-back reads allowed every cycle on both ports; throughput 1 req/port/cycle.
//  dout holds last read value while rvalid=0; writes never change dout or assert rvalid.
//  Collision rules (same addr, both en, READY):
//   A write + B write -> A's data stored, B's dropped; collision=1 next cycle.
//   Write + other port read -> read returns OLD data (read-first); collision=1 next cycle.
//   Read + read -> both get data, collision stays 0.
//  Reset mid-operation: in-flight reads discarded (no rvalid), memory re-cleared, init_done drops.
//  Address wrap: addr is ADDR_W bits, no out-of-range case exists.
// CONFIGURATION
//  DPRAM_PARITY_EN defined:
//   Array stores DATA_W+1 bits; extra bit = ^din (even parity), written on every write.
//   CLEAR writes all-zero word with parity 0.
//   Adds outputs a_perr/b_perr (1 bit): asserted with rvalid when stored parity != ^stored data.
//   Cleared by rst.
//  DPRAM_PARITY_EN undefined: array DATA_W bits, a_perr/b_perr ports do not exist.
//   All other timing identical.
// TESTING
//  Clear: rst 2 cycles then low -> init_done=0 for 16 cycles (ADDR_W=4), then 1.
//   Reads of addr 0..15 return 0x00.
//  Write/read: A writes 0xA5@3, B reads @3 next cycle -> b_dout=0xA5 with b_rvalid after READ_LAT.
//   Run with READ_LAT=1 and 2.
//  W/W collision: A writes 0x11@7, B writes 0x22@7 same cycle.
//   -> collision pulse, subsequent read @7 = 0x11.
//  R/W collision: mem[5]=0x33; A reads @5 while B writes 0x44@5.
//   -> a_dout=0x33 with collision=1; next read @5 = 0x44.
//  Reset mid-read: issue read, assert rst before rvalid.
//   -> no rvalid, dout=0, full clear repeated, prior data reads 0.
//  Parity (DPRAM_PARITY_EN): backdoor-flip bit 0 of mem[2].
//   -> read @2 gives a_rvalid=1 and a_perr=1; clean word gives a_perr=0.

Source files
------------

// File: rtl/dp_ram_sync_init.sv
// Single-clock true dual-port RAM with post-reset hardware clear, 1- or 2-cycle read latency,
// read-valid strobes and same-address collision detection. Optional parity: define DPRAM_PARITY_EN.
module dp_ram_sync_init #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_rvalid,
`ifdef DPRAM_PARITY_EN
  output logic              a_perr,
  output logic              b_perr,
`endif
  output logic              init_done,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef DPRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("dp_ram_sync_init: READ_LAT must be 1 or 2");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic              r_collision;
  logic              w_ready;

  logic [1:0]        w_en;
  logic [1:0]        w_wr;
  logic [1:0]        w_rd;
  logic [1:0]        w_we;
  logic [ADDR_W-1:0] w_addr  [2];
  logic [DATA_W-1:0] w_din   [2];
  logic [MEM_W-1:0]  w_wword [2];

  assign w_ready   = (r_state == ST_READY);
  assign w_en      = {b_en, a_en};
  assign w_wr      = {b_wr, a_wr};
  assign w_rd      = w_en & ~w_wr & {2{w_ready}};
  assign w_we      = w_en & w_wr & {2{w_ready}};
  assign w_addr[0] = a_addr;
  assign w_addr[1] = b_addr;
  assign w_din[0]  = a_din;
  assign w_din[1]  = b_din;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_ptr == '1) w_state_nxt = ST_READY;
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_clr_ptr <= '0;
    else if (r_state == ST_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
  end

  // Port A is written last so it wins a same-address write/write conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_ptr] <= '0;
      end else begin
        if (w_we[1]) r_mem[w_addr[1]] <= w_wword[1];
        if (w_we[0]) r_mem[w_addr[0]] <= w_wword[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_collision <= 1'b0;
    else     r_collision <= (&w_en) & w_ready & (a_addr == b_addr) & (|w_wr);
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [MEM_W-1:0]  w_rword;
    logic              w_ov;
    logic [MEM_W-1:0]  w_ow;
    logic [DATA_W-1:0] r_dout;
    logic              r_rvalid;

`ifdef DPRAM_PARITY_EN
    assign w_wword[p] = {^w_din[p], w_din[p]};
`else
    assign w_wword[p] = w_din[p];
`endif
    assign w_rword = r_mem[w_addr[p]];

    if (READ_LAT == 2) begin : g_lat2
      logic             r_s1_v;
      logic [MEM_W-1:0] r_s1_w;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1_v <= 1'b0;
          r_s1_w <= '0;
        end else begin
          r_s1_v <= w_rd[p];
          if (w_rd[p]) r_s1_w <= w_rword;
        end
      end
      assign w_ov = r_s1_v;
      assign w_ow = r_s1_w;
    end else begin : g_lat1
      assign w_ov = w_rd[p];
      assign w_ow = w_rword;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dout   <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_ov;
        if (w_ov) r_dout <= w_ow[DATA_W-1:0];
      end
    end

`ifdef DPRAM_PARITY_EN
    logic r_perr;
    always_ff @(posedge clk) begin
      if (rst) r_perr <= 1'b0;
      else     r_perr <= w_ov & (^w_ow);
    end
`endif
  end

  assign a_dout    = g_port[0].r_dout;
  assign a_rvalid  = g_port[0].r_rvalid;
  assign b_dout    = g_port[1].r_dout;
  assign b_rvalid  = g_port[1].r_rvalid;
`ifdef DPRAM_PARITY_EN
  assign a_perr    = g_port[0].r_perr;
  assign b_perr    = g_port[1].r_perr;
`endif
  assign init_done = w_ready;
  assign collision = r_collision;

endmodule

// File: tb/tb_dp_ram_sync_init.sv
// Bench for dp_ram_sync_init: one READ_LAT=1 and one READ_LAT=2 instance share stimulus;
// directed scenarios plus randomized traffic against an array-based reference model.
module tb_dp_ram_sync_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       a_en = 1'b0, a_wr = 1'b0, b_en = 1'b0, b_wr = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_din = '0, b_din = '0;

  logic [7:0] a1_dout, b1_dout, a2_dout, b2_dout;
  logic       a1_rv, b1_rv, a2_rv, b2_rv, init1, init2, col1, col2;
`ifdef DPRAM_PARITY_EN
  logic       a1_pe, b1_pe, a2_pe, b2_pe;
`endif

  dp_ram_sync_init #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(a1_dout), .a_rvalid(a1_rv),
    .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(b1_dout), .b_rvalid(b1_rv),
`ifdef DPRAM_PARITY_EN
    .a_perr(a1_pe), .b_perr(b1_pe),
`endif
    .init_done(init1), .collision(col1));

  dp_ram_sync_init #(.DATA_W(8), .ADDR_W(4), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_dout(a2_dout), .a_rvalid(a2_rv),
    .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_dout(b2_dout), .b_rvalid(b2_rv),
`ifdef DPRAM_PARITY_EN
    .a_perr(a2_pe), .b_perr(b2_pe),
`endif
    .init_done(init2), .collision(col2));

  // Observed outputs indexed [latency-1][port]
  logic [7:0] g_dout [2][2];
  logic       g_rv   [2][2];
  assign g_dout[0][0] = a1_dout; assign g_dout[0][1] = b1_dout;
  assign g_dout[1][0] = a2_dout; assign g_dout[1][1] = b2_dout;
  assign g_rv[0][0]   = a1_rv;   assign g_rv[0][1]   = b1_rv;
  assign g_rv[1][0]   = a2_rv;   assign g_rv[1][1]   = b2_rv;
`ifdef DPRAM_PARITY_EN
  logic       g_pe   [2][2];
  assign g_pe[0][0]   = a1_pe;   assign g_pe[0][1]   = b1_pe;
  assign g_pe[1][0]   = a2_pe;   assign g_pe[1][1]   = b2_pe;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: memory contents, clear progress, and a short history of issued reads.
  logic [7:0] m_mem [16];
  bit         m_pbad [16];
  bit         m_ready = 1'b0;
  int         m_ptr = 0;
  int         n_edge = 0;
  bit         hv [2][8];
  logic [7:0] hd [2][8];
  bit         hp [2][8];
  logic [7:0] e_dout [2][2];
  bit         e_rv [2][2];
  bit         e_pe [2][2];
  bit         e_col, e_init;

  function automatic void model_edge();
    int s;
    n_edge++;
    s = n_edge & 7;
    for (int p = 0; p < 2; p++) hv[p][s] = 1'b0;
    if (rst) begin
      m_ready = 1'b0;
      m_ptr   = 0;
      e_col   = 1'b0;
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 2; p++) begin
          e_dout[l][p] = 8'h00; e_rv[l][p] = 1'b0; e_pe[l][p] = 1'b0;
        end
    end else begin
      e_col = 1'b0;
      if (!m_ready) begin
        m_mem[m_ptr]  = 8'h00;
        m_pbad[m_ptr] = 1'b0;
        m_ptr++;
        if (m_ptr == 16) m_ready = 1'b1;
      end else begin
        if (a_en && !a_wr) begin hv[0][s] = 1'b1; hd[0][s] = m_mem[a_addr]; hp[0][s] = m_pbad[a_addr]; end
        if (b_en && !b_wr) begin hv[1][s] = 1'b1; hd[1][s] = m_mem[b_addr]; hp[1][s] = m_pbad[b_addr]; end
        e_col = a_en && b_en && (a_addr == b_addr) && (a_wr || b_wr);
        if (b_en && b_wr) begin m_mem[b_addr] = b_din; m_pbad[b_addr] = 1'b0; end
        if (a_en && a_wr) begin m_mem[a_addr] = a_din; m_pbad[a_addr] = 1'b0; end
      end
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 2; p++) begin
          int idx;
          idx = (n_edge - l) & 7;
          e_rv[l][p] = hv[p][idx];
          e_pe[l][p] = hv[p][idx] && hp[p][idx];
          if (hv[p][idx]) e_dout[l][p] = hd[p][idx];
        end
    end
    e_init = m_ready;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_wr = 1'b0; b_en = 1'b0; b_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    n_chk++;
    if (init1 !== 1'b0 || init2 !== 1'b0) $display("FAIL reset_init: got %b/%b want 0/0", init1, init2);
    else n_pass++;
    n_chk++;
    if (col1 !== 1'b0 || col2 !== 1'b0) $display("FAIL reset_collision: got %b/%b want 0/0", col1, col2);
    else n_pass++;
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 2; p++) begin
        n_chk++;
        if (g_rv[l][p] !== 1'b0 || g_dout[l][p] !== 8'h00)
          $display("FAIL reset_out lat%0d port%0d: got rv=%b dout=%h want rv=0 dout=00", l + 1, p, g_rv[l][p], g_dout[l][p]);
        else n_pass++;
      end
  endtask

  task automatic test_clear();
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_chk++;
      if (init1 !== (k == 16) || init2 !== (k == 16))
        $display("FAIL clear_init edge%0d: got %b/%b want %0d", k, init1, init2, (k == 16));
      else n_pass++;
    end
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        a_en = 1'b1; a_wr = 1'b0; a_addr = 4'(i);
        b_en = 1'b1; b_wr = 1'b0; b_addr = 4'(15 - i);
      end else idle();
      tick();
      if (i < 16) begin
        n_chk++;
        if (a1_rv !== 1'b1 || a1_dout !== 8'h00 || b1_rv !== 1'b1 || b1_dout !== 8'h00)
          $display("FAIL clear_read_lat1 addr%0d: got a=%b/%h b=%b/%h want 1/00", i, a1_rv, a1_dout, b1_rv, b1_dout);
        else n_pass++;
      end
      if (i > 0) begin
        n_chk++;
        if (a2_rv !== 1'b1 || a2_dout !== 8'h00 || b2_rv !== 1'b1 || b2_dout !== 8'h00)
          $display("FAIL clear_read_lat2 addr%0d: got a=%b/%h b=%b/%h want 1/00", i - 1, a2_rv, a2_dout, b2_rv, b2_dout);
        else n_pass++;
      end
    end
  endtask

  task automatic test_write_read();
    a_en = 1'b1; a_wr = 1'b1; a_addr = 4'd3; a_din = 8'hA5;
    tick();
    n_chk++;
    if (a1_rv !== 1'b0 || a2_rv !== 1'b0) $display("FAIL write_no_rvalid: got %b/%b want 0/0", a1_rv, a2_rv);
    else n_pass++;
    idle(); b_en = 1'b1; b_wr = 1'b0; b_addr = 4'd3;
    tick();
    n_chk++;
    if (b1_rv !== 1'b1 || b1_dout !== 8'hA5 || b2_rv !== 1'b0)
      $display("FAIL wr_rd_lat1: got rv1=%b dout1=%h rv2=%b want 1/a5/0", b1_rv, b1_dout, b2_rv);
    else n_pass++;
    idle();
    tick();
    n_chk++;
    if (b2_rv !== 1'b1 || b2_dout !== 8'hA5 || b1_rv !== 1'b0 || b1_dout !== 8'hA5)
      $display("FAIL wr_rd_lat2: got rv2=%b dout2=%h rv1=%b dout1=%h want 1/a5/0/a5", b2_rv, b2_dout, b1_rv, b1_dout);
    else n_pass++;
  endtask

  task automatic test_ww_collision();
    a_en = 1'b1; a_wr = 1'b1; a_addr = 4'd7; a_din = 8'h11;
    b_en = 1'b1; b_wr = 1'b1; b_addr = 4'd7; b_din = 8'h22;
    tick();
    n_chk++;
    if (col1 !== 1'b1 || col2 !== 1'b1) $display("FAIL ww_collision: got %b/%b want 1/1", col1, col2);
    else n_pass++;
    idle(); a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd7;
    tick();
    n_chk++;
    if (col1 !== 1'b0 || a1_rv !== 1'b1 || a1_dout !== 8'h11)
      $display("FAIL ww_read_lat1: got col=%b rv=%b dout=%h want 0/1/11", col1, a1_rv, a1_dout);
    else n_pass++;
    idle();
    tick();
    n_chk++;
    if (a2_rv !== 1'b1 || a2_dout !== 8'h11) $display("FAIL ww_read_lat2: got rv=%b dout=%h want 1/11", a2_rv, a2_dout);
    else n_pass++;
  endtask

  task automatic test_rw_collision();
    a_en = 1'b1; a_wr = 1'b1; a_addr = 4'd5; a_din = 8'h33;
    tick();
    a_wr = 1'b0;
    b_en = 1'b1; b_wr = 1'b1; b_addr = 4'd5; b_din = 8'h44;
    tick();
    n_chk++;
    if (a1_rv !== 1'b1 || a1_dout !== 8'h33 || col1 !== 1'b1 || col2 !== 1'b1)
      $display("FAIL rw_collision_lat1: got rv=%b dout=%h col=%b/%b want 1/33/1/1", a1_rv, a1_dout, col1, col2);
    else n_pass++;
    a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd5;
    b_en = 1'b1; b_wr = 1'b0; b_addr = 4'd5;
    tick();
    n_chk++;
    if (a2_rv !== 1'b1 || a2_dout !== 8'h33) $display("FAIL rw_collision_lat2: got rv=%b dout=%h want 1/33", a2_rv, a2_dout);
    else n_pass++;
    n_chk++;
    if (col1 !== 1'b0 || a1_dout !== 8'h44 || b1_dout !== 8'h44 || b1_rv !== 1'b1)
      $display("FAIL rr_same_addr: got col=%b a=%h b=%h brv=%b want 0/44/44/1", col1, a1_dout, b1_dout, b1_rv);
    else n_pass++;
    idle();
    tick();
    n_chk++;
    if (col2 !== 1'b0 || a2_dout !== 8'h44 || b2_dout !== 8'h44)
      $display("FAIL rr_same_addr_lat2: got col=%b a=%h b=%h want 0/44/44", col2, a2_dout, b2_dout);
    else n_pass++;
  endtask

  task automatic test_parity();
`ifdef DPRAM_PARITY_EN
    a_en = 1'b1; a_wr = 1'b1; a_addr = 4'd2; a_din = 8'h6C;
    b_en = 1'b1; b_wr = 1'b1; b_addr = 4'd4; b_din = 8'h01;
    tick();
    idle();
    u_lat1.r_mem[2][0] = ~u_lat1.r_mem[2][0];
    u_lat2.r_mem[2][0] = ~u_lat2.r_mem[2][0];
    m_mem[2][0] = ~m_mem[2][0];
    m_pbad[2] = 1'b1;
    a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd2;
    b_en = 1'b1; b_wr = 1'b0; b_addr = 4'd4;
    tick();
    n_chk++;
    if (a1_rv !== 1'b1 || a1_pe !== 1'b1 || b1_pe !== 1'b0 || a1_dout !== 8'h6D)
      $display("FAIL parity_lat1: got rv=%b aperr=%b bperr=%b dout=%h want 1/1/0/6d", a1_rv, a1_pe, b1_pe, a1_dout);
    else n_pass++;
    idle();
    tick();
    n_chk++;
    if (a2_rv !== 1'b1 || a2_pe !== 1'b1 || b2_pe !== 1'b0 || a1_pe !== 1'b0)
      $display("FAIL parity_lat2: got rv=%b aperr=%b bperr=%b aperr1=%b want 1/1/0/0", a2_rv, a2_pe, b2_pe, a1_pe);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_read();
    a_en = 1'b1; a_wr = 1'b1; a_addr = 4'd9; a_din = 8'h5A;
    tick();
    a_wr = 1'b0;
    tick();
    n_chk++;
    if (a1_rv !== 1'b1 || a1_dout !== 8'h5A) $display("FAIL midrst_pre: got rv=%b dout=%h want 1/5a", a1_rv, a1_dout);
    else n_pass++;
    idle(); rst = 1'b1;
    tick();
    n_chk++;
    if (a2_rv !== 1'b0 || a2_dout !== 8'h00 || a1_dout !== 8'h00 || init1 !== 1'b0 || init2 !== 1'b0)
      $display("FAIL midrst_flush: got rv2=%b dout2=%h dout1=%h init=%b/%b want 0/00/00/0/0", a2_rv, a2_dout, a1_dout, init1, init2);
    else n_pass++;
    rst = 1'b0;
    a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd9;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_chk++;
      if (init1 !== (k == 16) || init2 !== (k == 16) || a1_rv !== 1'b0 || a2_rv !== 1'b0)
        $display("FAIL midrst_clear edge%0d: got init=%b/%b rv=%b/%b want %0d/0", k, init1, init2, a1_rv, a2_rv, (k == 16));
      else n_pass++;
      if (k == 16) idle();
    end
    a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd9;
    tick();
    n_chk++;
    if (a1_rv !== 1'b1 || a1_dout !== 8'h00) $display("FAIL midrst_reread_lat1: got rv=%b dout=%h want 1/00", a1_rv, a1_dout);
    else n_pass++;
    idle();
    tick();
    n_chk++;
    if (a2_rv !== 1'b1 || a2_dout !== 8'h00) $display("FAIL midrst_reread_lat2: got rv=%b dout=%h want 1/00", a2_rv, a2_dout);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      a_en   = ($urandom_range(0, 3) != 0);
      a_wr   = $urandom_range(0, 1) == 1;
      a_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      a_din  = 8'($urandom);
      b_en   = ($urandom_range(0, 3) != 0);
      b_wr   = $urandom_range(0, 1) == 1;
      b_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      b_din  = 8'($urandom);
      tick();
      n_chk++;
      if (col1 !== e_col || col2 !== e_col || init1 !== e_init || init2 !== e_init)
        $display("FAIL rnd_ctrl cyc%0d: got col=%b/%b init=%b/%b want col=%b init=%b", c, col1, col2, init1, init2, e_col, e_init);
      else n_pass++;
      for (int l = 0; l < 2; l++)
        for (int p = 0; p < 2; p++) begin
          n_chk++;
          if (g_rv[l][p] !== e_rv[l][p] || g_dout[l][p] !== e_dout[l][p])
            $display("FAIL rnd_read cyc%0d lat%0d port%0d: got rv=%b dout=%h want rv=%b dout=%h",
                     c, l + 1, p, g_rv[l][p], g_dout[l][p], e_rv[l][p], e_dout[l][p]);
          else n_pass++;
`ifdef DPRAM_PARITY_EN
          n_chk++;
          if (g_pe[l][p] !== e_pe[l][p])
            $display("FAIL rnd_perr cyc%0d lat%0d port%0d: got %b want %b", c, l + 1, p, g_pe[l][p], e_pe[l][p]);
          else n_pass++;
`endif
        end
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_ww_collision();
    test_rw_collision();
    test_parity();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
